uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit half of the UART: accepts one parallel byte per frame and shifts it onto the serial line as start bit, 8 data bits (LSB first), optional parity bit and one stop bit. Bit timing uses the same PRESCALE convention as the receive path: every bit lasts exactly PRESCALE clock cycles. It sits between the system-side data source and the TX pad and is the line-level counterpart of the RX sampler/edge-bit counter.

## Interface
- DATA_WIDTH, 8, payload bits per frame; only 8 is verified.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  byte to send; sampled on the accept edge.
- DATA_VALID  input  1  request to send P_DATA; honoured only in IDLE.
- PAR_EN  input  1  1 = insert a parity bit; sampled on the accept edge.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on the accept edge.
- PRESCALE  input  6  clock cycles per bit; sampled on the accept edge.
- TX_OUT  output  1  serial line, registered; idles high.
- Busy  output  1  registered; high from the first start-bit cycle through the last stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If DATA_VALID=1 on an edge, that edge is the accept edge:
  - latch P_DATA, PAR_EN, PAR_TYP and PRESCALE;
  - compute the parity bit: XOR of the data, inverted when PAR_TYP=1;
  - go to START.
- START: TX_OUT=0 for P cycles, then go to DATA.
- DATA: TX_OUT=data[bit_cnt], bit_cnt 0..7, LSB first, each bit for P cycles. After bit 7, go to PARITY if PAR_EN is latched high, else go to STOP.
- PARITY: TX_OUT=parity bit for P cycles, then go to STOP.
- STOP: TX_OUT=1 for P cycles, then go to IDLE.
- Internal counters:
  - edge_cnt (6 bits) counts 0..P-1 within a bit and wraps to 0 at P-1;
  - bit_cnt (4 bits) advances on each edge_cnt wrap in DATA;
  - both are cleared on every state change.
- P is the latched PRESCALE. A latched value of 0 is clamped to 1. The legal range is 1..63 and the bench drives only this range.
- While Busy=1:
  - DATA_VALID is ignored; there is no queueing;
  - changes on P_DATA, PAR_EN, PAR_TYP and PRESCALE have no effect on the frame in flight.
- Reset at any time, mid-frame included: on the next edge the state is IDLE, TX_OUT=1, Busy=0 and all counters are 0. The partial frame is abandoned, with no stop bit appended.

## Timing
- Reset values: TX_OUT=1, Busy=0, state IDLE, edge_cnt=0, bit_cnt=0, data and parity registers 0.
- Accept at edge k:
  - TX_OUT=0 and Busy=1 are visible from cycle k+1 (one-cycle latency);
  - the frame occupies cycles k+1 .. k+N·P, where N=10 (PAR_EN=0) or 11 (PAR_EN=1);
  - bit j (start is j=0) occupies cycles k+1+j·P .. k+(j+1)·P.
- Frame end: at edge k+N·P the block returns to IDLE. Busy=0 and TX_OUT=1 from cycle k+N·P+1.
- Back-to-back frames: DATA_VALID held high gives one IDLE cycle between frames. The next accept is at edge k+N·P+1, and the next start bit begins at cycle k+N·P+2.
- DATA_VALID and rst high on the same edge: reset wins and nothing is accepted.
- P=1 is legal and yields one cycle per bit.
- TX_OUT is glitch-free: driven directly from a flop, never from combinational decode.

## Test plan
- Reset/idle: assert rst for 3 cycles, then hold DATA_VALID=0 for 50 cycles -> TX_OUT=1 and Busy=0 throughout.
- No parity: PRESCALE=8, PAR_EN=0, P_DATA=0xA5, one-cycle DATA_VALID -> line reads 0,1,0,1,0,0,1,0,1,1, each bit exactly 8 cycles; Busy high for exactly 80 cycles.
- Parity:
  - PRESCALE=4, PAR_EN=1, P_DATA=0xA5, PAR_TYP=0 -> parity bit 0, 11 bits, Busy high 44 cycles;
  - repeat with PAR_TYP=1 -> parity bit 1;
  - P_DATA=0x00 with PAR_TYP=1 -> parity bit 1.
- Ignored request and held config: during a frame, pulse DATA_VALID with P_DATA=0xFF and change PRESCALE to 3 -> the frame in flight is unchanged, and no second frame follows.
- Back-to-back: PRESCALE=1, DATA_VALID held high with 0x55 then 0x0F -> exactly one TX_OUT=1/Busy=0 cycle between frames; both frames are bit-exact.
- Mid-frame reset: PRESCALE=16, assert rst during data bit 3 for 1 cycle -> TX_OUT=1 and Busy=0 on the next cycle. A new request after reset produces a full, correct frame from its start bit.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit framer.
// Start bit, LSB-first payload, optional parity, one stop bit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            PRESCALE,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [5:0]            edge_cnt;
    logic [5:0]            edge_nxt;
    logic [3:0]            bit_cnt;
    logic [3:0]            bit_nxt;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  par_r;
    logic                  par_en_r;
    logic [5:0]            presc_r;
    logic                  accept;
    logic                  bit_end;
    logic                  last_bit;
    logic                  tx_d;
    logic                  busy_d;

    assign bit_end  = (edge_cnt == presc_r - 6'd1);
    assign last_bit = (bit_cnt == 4'(DATA_WIDTH - 1));

    // State and bit-timing counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
        end else begin
            state    <= state_nxt;
            edge_cnt <= edge_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    // Frame configuration, captured once per frame so the
    // frame in flight ignores later input changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r   <= '0;
            par_r    <= 1'b0;
            par_en_r <= 1'b0;
            presc_r  <= 6'd0;
        end else if (accept) begin
            data_r   <= P_DATA;
            par_r    <= (^P_DATA) ^ PAR_TYP;
            par_en_r <= PAR_EN;
            presc_r  <= (PRESCALE == 6'd0) ? 6'd1 : PRESCALE;
        end
    end

    // Next state, counters, and next line level.
    always_comb begin
        state_nxt = state;
        edge_nxt  = edge_cnt;
        bit_nxt   = bit_cnt;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                edge_nxt = 6'd0;
                bit_nxt  = 4'd0;
                if (DATA_VALID) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    edge_nxt  = 6'd0;
                    bit_nxt   = 4'd0;
                    state_nxt = DATA;
                end else begin
                    edge_nxt = edge_cnt + 6'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    edge_nxt = 6'd0;
                    if (last_bit) begin
                        bit_nxt   = 4'd0;
                        state_nxt = par_en_r ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end else begin
                    edge_nxt = edge_cnt + 6'd1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    edge_nxt  = 6'd0;
                    state_nxt = STOP;
                end else begin
                    edge_nxt = edge_cnt + 6'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    edge_nxt  = 6'd0;
                    state_nxt = IDLE;
                end else begin
                    edge_nxt = edge_cnt + 6'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                edge_nxt  = 6'd0;
                bit_nxt   = 4'd0;
            end
        endcase
    end

    // Line level and busy flag for the coming cycle,
    // decoded from the next state so the outputs can be flops.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        unique case (state_nxt)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_r[bit_nxt[IW-1:0]];
            PARITY:  tx_d = par_r;
            STOP:    tx_d = 1'b1;
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs keep the serial line glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
        end else begin
            TX_OUT <= tx_d;
            Busy   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench for the UART framer.
// Expected line levels are queued per cycle and compared each cycle.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       Busy;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit tx;
        int frame;
        int bitn;
    } exp_t;

    exp_t exp_q[$];
    int   rem     = 0;
    int   nframes = 0;
    int   errors  = 0;
    int   checks  = 0;
    bit   mon_en  = 0;

    // Reference model: frame = list of bit values, each held P cycles.
    always @(posedge clk) begin
        bit   bits[$];
        int   p;
        bit   par;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            rem = 0;
        end else if (rem > 0) begin
            rem--;
        end else if (DATA_VALID) begin
            p = (PRESCALE == 0) ? 1 : int'(PRESCALE);
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(P_DATA[i]);
            if (PAR_EN) begin
                par = (($countones(P_DATA) % 2) == 1);
                if (PAR_TYP) par = ~par;
                bits.push_back(par);
            end
            bits.push_back(1'b1);
            for (int j = 0; j < bits.size(); j++) begin
                for (int c = 0; c < p; c++) begin
                    e.tx    = bits[j];
                    e.frame = nframes;
                    e.bitn  = j;
                    exp_q.push_back(e);
                end
            end
            rem = bits.size() * p;
            nframes++;
        end
    end

    // Monitor: one comparison of line level and busy per cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   etx;
        bit   ebusy;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                etx   = e.tx;
                ebusy = 1'b1;
            end else begin
                e.frame = -1;
                e.bitn  = -1;
                etx     = 1'b1;
                ebusy   = 1'b0;
            end
            checks++;
            if (TX_OUT !== etx || Busy !== ebusy) begin
                errors++;
                $display("FAIL line t=%0t frame=%0d bit=%0d: got tx=%b busy=%b, want tx=%b busy=%b",
                         $time, e.frame, e.bitn, TX_OUT, Busy, etx, ebusy);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] d, input logic en,
                           input logic typ, input logic [5:0] p);
        P_DATA   = d;
        PAR_EN   = en;
        PAR_TYP  = typ;
        PRESCALE = p;
    endtask

    task automatic send(input logic [7:0] d, input logic en,
                        input logic typ, input logic [5:0] p);
        set_cfg(d, en, typ, p);
        DATA_VALID = 1'b1;
        tick(1);
        DATA_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rem != 0 && n < 5000) begin
            tick(1);
            n++;
        end
        checks++;
        if (rem != 0) begin
            errors++;
            $display("FAIL wait_idle: frame still running after %0d cycles, want done", n);
        end
    endtask

    initial begin
        rst        = 1'b1;
        DATA_VALID = 1'b0;
        set_cfg(8'h00, 1'b0, 1'b0, 6'd8);
        tick(1);
        mon_en = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(50);

        send(8'hA5, 1'b0, 1'b0, 6'd8);
        wait_idle();
        tick(3);

        send(8'hA5, 1'b1, 1'b0, 6'd4);
        wait_idle();
        tick(2);
        send(8'hA5, 1'b1, 1'b1, 6'd4);
        wait_idle();
        tick(2);
        send(8'h00, 1'b1, 1'b1, 6'd4);
        wait_idle();
        tick(2);

        send(8'h3C, 1'b1, 1'b0, 6'd8);
        tick(30);
        set_cfg(8'hFF, 1'b0, 1'b1, 6'd3);
        DATA_VALID = 1'b1;
        tick(1);
        DATA_VALID = 1'b0;
        wait_idle();
        tick(20);

        set_cfg(8'h55, 1'b0, 1'b0, 6'd1);
        DATA_VALID = 1'b1;
        tick(1);
        P_DATA = 8'h0F;
        tick(11);
        DATA_VALID = 1'b0;
        wait_idle();
        tick(5);

        send(8'h96, 1'b0, 1'b0, 6'd16);
        tick(70);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(4);
        rst        = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA     = 8'h77;
        tick(1);
        rst        = 1'b0;
        DATA_VALID = 1'b0;
        tick(4);
        send(8'hC3, 1'b1, 1'b1, 6'd16);
        wait_idle();
        tick(3);

        for (int it = 0; it < 25; it++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom),
                 6'($urandom_range(1, 10)));
            for (int c = 0; c < int'($urandom_range(0, 12)); c++) begin
                P_DATA     = 8'($urandom);
                PRESCALE   = 6'($urandom_range(1, 63));
                PAR_EN     = 1'($urandom);
                DATA_VALID = ($urandom_range(0, 3) == 0);
                tick(1);
            end
            DATA_VALID = 1'b0;
            wait_idle();
            tick($urandom_range(0, 3));
        end

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles left, want 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
